// File: rtl/ahblite_seg_scan.sv
// ahblite_seg_scan: AHB-Lite slave that scans up to eight hex digits onto a
// multiplexed 7-segment display with leading-zero suppress, blanking and dp.
module ahblite_seg_scan #(
   parameter int NDIG         = 4,
   parameter int DIV_W        = 16,
   parameter int PRESCALE_RST = 49999,
   parameter int ACT_LOW      = 1
) (
   input  logic            HCLK,
   input  logic            HRESET,
   input  logic            HSEL,
   input  logic [31:0]     HADDR,
   input  logic [1:0]      HTRANS,
   input  logic [2:0]      HSIZE,
   input  logic [3:0]      HPROT,
   input  logic            HWRITE,
   input  logic [31:0]     HWDATA,
   input  logic            HREADY,
   output logic            HREADYOUT,
   output logic            HRESP,
   output logic [31:0]     HRDATA,
   output logic [7:0]      seg,
   output logic [NDIG-1:0] an
);
   logic            dp_valid, dp_write;
   logic [1:0]      dp_addr, dp_lane, dp_size;
   logic [4*NDIG-1:0] data;
   logic            en, lzs;
   logic [NDIG-1:0] dpm, blk;
   logic [DIV_W-1:0] prescale, cnt;
   logic [2:0]      idx;
   logic            tick_flag, tick, wr, clr_tick;
   logic [3:0]      be;
   logic [31:0]     wmask, data_r, ctrl_r, ps_r, status_r, data_pad;
   logic [7:0]      lz, dp_pad, blk_pad, seg_act;
   logic [3:0]      nib;
   logic [6:0]      hex;
   logic            blank, z;
   logic [NDIG-1:0] an_act;
   logic            unused;

   assign unused    = &{1'b0, HPROT, HADDR, HTRANS, HSIZE, HWDATA, wmask};
   assign HREADYOUT = 1'b1;
   assign HRESP     = 1'b0;
   assign be        = dp_size[1] ? 4'hF : dp_size[0] ? (dp_lane[1] ? 4'hC : 4'h3) : 4'b0001 << dp_lane;
   assign wmask     = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
   assign wr        = dp_valid & dp_write;
   assign clr_tick  = wr & (dp_addr == 2'd3) & be[1] & HWDATA[8];
   assign tick      = en & (cnt == prescale);
   assign data_r    = 32'(data);
   assign ctrl_r    = {8'h0, 8'(blk), 8'(dpm), 6'h0, lzs, en};
   assign ps_r      = 32'(prescale);
   assign status_r  = {23'h0, tick_flag, 5'h0, idx};
   assign HRDATA    = dp_addr == 2'd0 ? data_r : dp_addr == 2'd1 ? ctrl_r : dp_addr == 2'd2 ? ps_r : status_r;

   always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET) begin
         dp_valid <= 1'b0;
         dp_write <= 1'b0;
         dp_addr  <= 2'd0;
         dp_lane  <= 2'd0;
         dp_size  <= 2'd0;
      end else begin
         dp_valid <= HSEL & HREADY & HTRANS[1];
         if (HSEL & HREADY & HTRANS[1]) begin
            dp_write <= HWRITE;
            dp_addr  <= HADDR[3:2];
            dp_lane  <= HADDR[1:0];
            dp_size  <= HSIZE[1:0];
         end
      end
   end

   // Register writes land one edge after the address phase; tick beats a TICK clear.
   always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET) begin
         data      <= '0;
         en        <= 1'b1;
         lzs       <= 1'b0;
         dpm       <= '0;
         blk       <= '0;
         prescale  <= DIV_W'(PRESCALE_RST);
         cnt       <= '0;
         idx       <= 3'd0;
         tick_flag <= 1'b0;
      end else begin
         if (wr && dp_addr == 2'd0)
            data <= (data & ~wmask[4*NDIG-1:0]) | (HWDATA[4*NDIG-1:0] & wmask[4*NDIG-1:0]);
         if (wr && dp_addr == 2'd1) begin
            if (be[0]) en  <= HWDATA[0];
            if (be[0]) lzs <= HWDATA[1];
            if (be[1]) dpm <= HWDATA[8 +: NDIG];
            if (be[2]) blk <= HWDATA[16 +: NDIG];
         end
         if (wr && dp_addr == 2'd2) begin
            prescale <= (prescale & ~wmask[DIV_W-1:0]) | (HWDATA[DIV_W-1:0] & wmask[DIV_W-1:0]);
            cnt      <= '0;
         end else if (en)
            cnt <= tick ? '0 : cnt + 1'b1;
         if (tick)
            idx <= idx == 3'(NDIG - 1) ? 3'd0 : idx + 3'd1;
         tick_flag <= tick | (tick_flag & ~clr_tick);
      end
   end

   always_comb begin
      data_pad = 32'(data);
      dp_pad   = 8'(dpm);
      blk_pad  = 8'(blk);
      lz       = '0;
      z        = 1'b1;
      for (int i = 7; i >= 0; i--) begin
         z     = z & (data_pad[4*i +: 4] == 4'h0);
         lz[i] = z;
      end
      nib = data_pad[{idx, 2'b00} +: 4];
      hex = 7'h00;
      case (nib)
         4'h0: hex = 7'h3F;
         4'h1: hex = 7'h06;
         4'h2: hex = 7'h5B;
         4'h3: hex = 7'h4F;
         4'h4: hex = 7'h66;
         4'h5: hex = 7'h6D;
         4'h6: hex = 7'h7D;
         4'h7: hex = 7'h07;
         4'h8: hex = 7'h7F;
         4'h9: hex = 7'h6F;
         4'hA: hex = 7'h77;
         4'hB: hex = 7'h7C;
         4'hC: hex = 7'h39;
         4'hD: hex = 7'h5E;
         4'hE: hex = 7'h79;
         default: hex = 7'h71;
      endcase
      blank   = blk_pad[idx] | (lzs & (idx != 3'd0) & lz[idx]);
      seg_act = en ? {dp_pad[idx], blank ? 7'h00 : hex} : 8'h00;
      an_act  = en ? NDIG'(8'd1 << idx) : '0;
   end

   always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET) begin
         seg <= (ACT_LOW != 0) ? 8'hFF : 8'h00;
         an  <= (ACT_LOW != 0) ? '1 : '0;
      end else begin
         seg <= (ACT_LOW != 0) ? ~seg_act : seg_act;
         an  <= (ACT_LOW != 0) ? ~an_act : an_act;
      end
   end
endmodule

// File: doc/ahblite_seg_scan.md
AHBLITE_SEG_SCAN -- requirements
Module: ahblite_seg_scan

Interface
REQ-001 Parameter NDIG, default 4, number of multiplexed digits (legal 1..8).
REQ-002 Parameter DIV_W, default 16, prescaler width in bits.
REQ-003 Parameter PRESCALE_RST, default 49999, reset value of PRESCALE.
REQ-004 Parameter ACT_LOW, default 1; 1 = seg/an active-low, 0 = active-high.
REQ-005 HCLK  input  1  single clock; all logic on rising edge.
REQ-006 HRESET  input  1  reset, asynchronous, active-high.
REQ-007 HSEL, HADDR[31:0], HTRANS[1:0], HSIZE[2:0], HPROT[3:0], HWRITE, HWDATA[31:0], HREADY  input  AHB-Lite slave inputs; HPROT ignored.
REQ-008 HREADYOUT  output  1  tied 1; HRESP  output  1  tied 0 (OKAY).
REQ-009 HRDATA  output  32  read data.
REQ-010 seg  output  8  segments {dp,g,f,e,d,c,b,a}.
REQ-011 an  output  NDIG  digit enables, one-hot when lit.

Function
REQ-012 Register map on HADDR[3:2]: 0 DATA (4*NDIG bits, nibble i = digit i), 1 CTRL, 2 PRESCALE (DIV_W bits), 3 STATUS (read-only).
REQ-013 CTRL bits: [0] EN, [1] LZS (leading-zero suppress), [15:8] DP mask, [23:16] BLANK mask; only bits for digits <NDIG implemented; others read 0.
REQ-014 STATUS: [2:0] current digit index, [8] TICK sticky flag; writing 1 to bit 8 clears TICK.
REQ-015 Address phase qualified by HSEL & HREADY & HTRANS[1]; HADDR[3:2], HADDR[1:0], HSIZE, HWRITE latched into data-phase registers.
REQ-016 Write applied at end of the data phase (clock edge after the address-phase edge), byte lanes honoured: byte writes one lane, halfword two lanes per HADDR[1], word all four.
REQ-017 Unimplemented bits ignore writes; writes to STATUS except bit 8 have no effect.
REQ-018 HRDATA combinational from latched read address and current registers, zero-extended; back-to-back write then read to same register returns the new value.
REQ-019 Prescaler counts 0..PRESCALE while EN=1; on reaching PRESCALE it returns to 0 and emits a one-cycle tick.
REQ-020 Tick advances digit index by 1, wrapping NDIG-1 -> 0, and sets TICK.
REQ-021 Writing PRESCALE resets prescaler count to 0 same edge; PRESCALE=0 gives a tick every cycle.
REQ-022 EN=0: prescaler and index hold, an all inactive, seg all inactive.
REQ-023 Digit i hex-decoded 0-F to standard 7-segment patterns; dp driven by DP[i].
REQ-024 Digit blanked (segments a-g inactive, dp still from DP[i]) if BLANK[i], or LZS=1 and all nibbles i..NDIG-1 are zero and i!=0.
REQ-025 seg and an are registered: reflect index and register state of the previous cycle (one-cycle latency).
REQ-026 ACT_LOW inverts seg and an at the output register only.
REQ-027 Tick and TICK-clear write on same edge: set wins.

Reset
REQ-028 HRESET asserted asynchronously clears DATA=0, CTRL=0x0000_0001, PRESCALE=PRESCALE_RST, prescaler=0, index=0, TICK=0, latched data-phase controls inactive.
REQ-029 During reset seg and an drive inactive level (all 1 when ACT_LOW=1); reset mid-transfer discards the pending write.
REQ-030 First lit digit after reset release is digit 0, one cycle after release.

Verification
REQ-031 Reset then word write DATA=0x1234, PRESCALE=3 -> an cycles digit0..3 every 4 cycles, seg shows 4,3,2,1 (0x99,0xB0,0xA4,0xF9 active-low, no dp).
REQ-032 Byte write 0xAB to DATA offset 1 (HSIZE=0, HADDR=0x1) after 0x1234 -> DATA reads 0x0000AB34.
REQ-033 DATA=0x0005, CTRL=0x3 -> digits 3..1 blanked (seg 0xFF), digit0 shows 5 (0x92); DATA=0x0105 -> digit2 shows 1, digit1 shows 0.
REQ-034 PRESCALE=0, EN=1 -> index increments every cycle, wraps 3->0; STATUS[8]=1; write 0x100 to STATUS with no tick that cycle -> reads 0.
REQ-035 CTRL write EN=0 mid-scan -> an=0xF (inactive) next cycle, STATUS index frozen; EN=1 resumes from same index.
REQ-036 HRESET pulse during a DATA write data phase -> DATA reads 0 afterwards, seg/an inactive while reset high.
